// File: rtl/bus_demux_pkg.sv
// Shared types and constants for the 1-to-4 load/store bus demultiplexer.
package bus_demux_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_e;

   localparam int NUM_TARGETS        = 4;
   localparam int SEL_W              = 2;
   localparam int TIMEOUT_CYCLES_DEF = 255;
   localparam int WDOG_CNT_W         = 16;

   function automatic logic [NUM_TARGETS-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
      return NUM_TARGETS'(1) << sel;
   endfunction

endpackage

// File: rtl/bus_demux_watchdog.sv
// Cycle counter that flags a target which stalls a request or a read response too long.
module bus_demux_watchdog
   import bus_demux_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic run_i,
   output logic expired_o
);

   logic [WDOG_CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         cnt_q <= '0;
      end else if (run_i) begin
         cnt_q <= cnt_q + WDOG_CNT_W'(1);
      end
   end

   // Fires during the TIMEOUT_CYCLES-th waiting cycle so the FSM leaves on that edge.
   assign expired_o = run_i && (cnt_q == WDOG_CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/bus_demux_1_to_4.sv
// Single-outstanding load/store demux: one core request channel to four targets.
// Optional request/response watchdog is enabled by defining BUS_DEMUX_TIMEOUT_EN.
module bus_demux_1_to_4
   import bus_demux_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int SEL_LSB        = 28,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              req_valid_i,
   output logic                              req_ready_o,
   input  logic [ADDR_WIDTH-1:0]             req_addr_i,
   input  logic [DATA_WIDTH-1:0]             req_wdata_i,
   input  logic                              req_we_i,
   output logic                              resp_valid_o,
   output logic [DATA_WIDTH-1:0]             resp_rdata_o,
   output logic                              resp_err_o,
   output logic [NUM_TARGETS-1:0]            s_valid_o,
   input  logic [NUM_TARGETS-1:0]            s_ready_i,
   output logic [ADDR_WIDTH-1:0]             s_addr_o,
   output logic [DATA_WIDTH-1:0]             s_wdata_o,
   output logic                              s_we_o,
   input  logic [NUM_TARGETS-1:0]            s_rvalid_i,
   input  logic [NUM_TARGETS*DATA_WIDTH-1:0] s_rdata_i
);

   // Handshakes: a core request transfers on a rising edge with req_valid_i & req_ready_o;
   // a target transfer happens on an edge with s_valid_o[n] & s_ready_i[n], and until then
   // s_valid_o and the shared addr/wdata/we stay stable. Read data transfers on s_rvalid_i[n].
   state_e                  state_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic                    we_q;
   logic [SEL_W-1:0]        sel_q;
   logic [SEL_W-1:0]        sel_d;
   logic [NUM_TARGETS-1:0]  s_valid_q;
   logic                    resp_valid_q;
   logic                    resp_err_q;
   logic [DATA_WIDTH-1:0]   resp_rdata_q;
   logic [DATA_WIDTH-1:0]   rdata_sel;
   logic                    s_hs;
   logic                    s_rv;
   logic                    expired;

   assign sel_d     = req_addr_i[SEL_LSB +: SEL_W];
   assign s_hs      = s_ready_i[sel_q];
   assign s_rv      = s_rvalid_i[sel_q];
   assign rdata_sel = s_rdata_i[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];

`ifdef BUS_DEMUX_TIMEOUT_EN
   logic wdog_clear;
   logic wdog_run;

   assign wdog_clear = ((state_q == IDLE) && req_valid_i) ||
                       ((state_q == REQ) && s_hs && !we_q);
   assign wdog_run   = (state_q == REQ) || (state_q == WAIT);

   bus_demux_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (wdog_clear),
      .run_i     (wdog_run),
      .expired_o (expired)
   );
`else
   // Without the watchdog a silent target simply holds the bus; the limit is unused.
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign expired        = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         sel_q        <= '0;
         s_valid_q    <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  addr_q    <= req_addr_i;
                  wdata_q   <= req_wdata_i;
                  we_q      <= req_we_i;
                  sel_q     <= sel_d;
                  s_valid_q <= sel_onehot(sel_d);
                  state_q   <= REQ;
               end
            end
            REQ: begin
               if (s_hs) begin
                  s_valid_q <= '0;
                  if (we_q) begin
                     resp_valid_q <= 1'b1;
                     resp_rdata_q <= '0;
                     state_q      <= RESP;
                  end else begin
                     state_q <= WAIT;
                  end
               end else if (expired) begin
                  s_valid_q    <= '0;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
                  resp_rdata_q <= '0;
                  state_q      <= RESP;
               end
            end
            WAIT: begin
               if (s_rv) begin
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= rdata_sel;
                  state_q      <= RESP;
               end else if (expired) begin
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
                  resp_rdata_q <= '0;
                  state_q      <= RESP;
               end
            end
            RESP: begin
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               state_q      <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign req_ready_o  = (state_q == IDLE) && !rst_i;
   assign resp_valid_o = resp_valid_q;
   assign resp_rdata_o = resp_rdata_q;
   assign resp_err_o   = resp_err_q;
   assign s_valid_o    = s_valid_q;
   assign s_addr_o     = addr_q;
   assign s_wdata_o    = wdata_q;
   assign s_we_o       = we_q;

endmodule

// File: tb/tb_bus_demux_1_to_4.sv
// Self-checking bench for bus_demux_1_to_4: vector table, directed corner sequences, random traffic.
module tb_bus_demux_1_to_4;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         req_valid_i;
   logic         req_ready_o;
   logic [31:0]  req_addr_i;
   logic [31:0]  req_wdata_i;
   logic         req_we_i;
   logic         resp_valid_o;
   logic [31:0]  resp_rdata_o;
   logic         resp_err_o;
   logic [3:0]   s_valid_o;
   logic [3:0]   s_ready_i;
   logic [31:0]  s_addr_o;
   logic [31:0]  s_wdata_o;
   logic         s_we_o;
   logic [3:0]   s_rvalid_i;
   logic [127:0] s_rdata_i;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      int          rdy_dly;
      int          rv_dly;
      logic [31:0] rdata;
      logic        noise;
      int          exp_lat;
      logic [3:0]  exp_oh;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[6];

   bus_demux_1_to_4 #(
      .DATA_WIDTH     (32),
      .ADDR_WIDTH     (32),
      .SEL_LSB        (28),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_addr_i   (req_addr_i),
      .req_wdata_i  (req_wdata_i),
      .req_we_i     (req_we_i),
      .resp_valid_o (resp_valid_o),
      .resp_rdata_o (resp_rdata_o),
      .resp_err_o   (resp_err_o),
      .s_valid_o    (s_valid_o),
      .s_ready_i    (s_ready_i),
      .s_addr_o     (s_addr_o),
      .s_wdata_o    (s_wdata_o),
      .s_we_o       (s_we_o),
      .s_rvalid_i   (s_rvalid_i),
      .s_rdata_i    (s_rdata_i)
   );

   // clock / global time limit
   always #5 clk_i = ~clk_i;

   initial begin
      #400000;
      failures++;
      $display("FAIL global_timeout: actual=still running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "global time limit");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @%0t: actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   // Reference model: latency counted in edges from the accept edge to the first
   // cycle where resp_valid_o is seen. REQ costs 1 + ready stall, WAIT costs rv_dly.
   function automatic int model_lat(input logic we, input int rdy, input int rv);
      return we ? (2 + rdy) : (2 + rdy + rv);
   endfunction

   task automatic clear_targets();
      s_ready_i  = '0;
      s_rvalid_i = '0;
      s_rdata_i  = '0;
   endtask

   // One complete transaction; the target behaviour follows the given stall counts.
   task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                         input int rdy_dly, input int rv_dly, input logic [31:0] rdata,
                         input logic noise, input int exp_lat, input logic [3:0] exp_oh,
                         input logic [31:0] exp_rdata);
      int wait_cnt;
      logic [31:0] exp_d;
      wait_cnt = 0;
      exp_q.push_back(exp_rdata);
      @(negedge clk_i);
      while (!req_ready_o && wait_cnt < 16) begin
         @(negedge clk_i);
         wait_cnt++;
      end
      if (!req_ready_o) begin
         checks++;
         failures++;
         $display("FAIL accept_wait: actual=req_ready_o low for 16 cycles required=high");
         void'(exp_q.pop_front());
         return;
      end
      req_valid_i = 1'b1;
      req_addr_i  = addr;
      req_wdata_i = wdata;
      req_we_i    = we;
      for (int n = 1; n <= exp_lat + 1; n++) begin
         @(negedge clk_i);
         if (n == 1) begin
            req_valid_i = 1'b0;
            req_addr_i  = $urandom;
            req_wdata_i = $urandom;
            req_we_i    = 1'($urandom_range(0, 1));
         end
         chk("s_valid", s_valid_o, (n <= 1 + rdy_dly) ? exp_oh : 4'b0000);
         chk("s_addr", s_addr_o, addr);
         chk("s_wdata", s_wdata_o, wdata);
         chk("s_we", s_we_o, we);
         chk("req_ready", req_ready_o, (n == exp_lat + 1));
         chk("resp_valid", resp_valid_o, (n == exp_lat));
         if (n == exp_lat) begin
            exp_d = exp_q.pop_front();
            chk("resp_rdata", resp_rdata_o, exp_d);
            chk("resp_err", resp_err_o, 1'b0);
         end
         if (n == exp_lat + 1) chk("resp_rdata_hold", resp_rdata_o, exp_rdata);
         s_ready_i  = noise ? ~exp_oh : 4'b0000;
         s_rvalid_i = noise ? ~exp_oh : 4'b0000;
         if (n == 1 + rdy_dly) s_ready_i = s_ready_i | exp_oh;
         if (!we && n == 1 + rdy_dly + rv_dly) s_rvalid_i = s_rvalid_i | exp_oh;
         for (int t = 0; t < 4; t++)
            s_rdata_i[t*32 +: 32] = exp_oh[t] ? rdata : (noise ? 32'h1111_1111 : $urandom);
      end
      clear_targets();
   endtask

   initial begin
      logic [31:0] r_addr;
      logic [31:0] r_wdata;
      logic [31:0] r_rdata;
      logic        r_we;
      logic        r_noise;
      logic [3:0]  r_oh;
      int          r_rdy;
      int          r_rv;
      logic [31:0] exp_d;

      //                 addr          wdata         we    rdy rv rdata         noise lat oh       exp_rdata
      vecs[0] = '{32'h2000_0010, 32'hA5A5_0001, 1'b1, 0, 1, 32'h9999_9999, 1'b0, 2, 4'b0100, 32'h0};
      vecs[1] = '{32'h1000_0004, 32'h0000_0000, 1'b0, 3, 2, 32'hDEAD_BEEF, 1'b1, 7, 4'b0010, 32'hDEAD_BEEF};
      vecs[2] = '{32'h0000_0100, 32'h0000_0000, 1'b0, 4, 1, 32'h1234_5678, 1'b1, 7, 4'b0001, 32'h1234_5678};
      vecs[3] = '{32'h3000_0000, 32'h0F0F_F0F0, 1'b1, 2, 1, 32'h5555_5555, 1'b1, 4, 4'b1000, 32'h0};
      vecs[4] = '{32'hF000_0000, 32'h0000_0000, 1'b0, 0, 1, 32'hCAFE_F00D, 1'b0, 3, 4'b1000, 32'hCAFE_F00D};
      vecs[5] = '{32'h4000_0000, 32'h0000_0000, 1'b0, 0, 1, 32'h0BAD_F00D, 1'b0, 3, 4'b0001, 32'h0BAD_F00D};

      // reset
      rst_i       = 1'b1;
      req_valid_i = 1'b0;
      req_addr_i  = '0;
      req_wdata_i = '0;
      req_we_i    = 1'b0;
      clear_targets();
      repeat (3) @(negedge clk_i);
      chk("rst_req_ready", req_ready_o, 1'b0);
      chk("rst_s_valid", s_valid_o, 4'b0000);
      chk("rst_resp_valid", resp_valid_o, 1'b0);
      chk("rst_resp_err", resp_err_o, 1'b0);
      chk("rst_resp_rdata", resp_rdata_o, 32'h0);
      chk("rst_s_addr", s_addr_o, 32'h0);
      chk("rst_s_wdata", s_wdata_o, 32'h0);
      chk("rst_s_we", s_we_o, 1'b0);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("post_rst_req_ready", req_ready_o, 1'b1);

      // table-driven vectors
      for (int i = 0; i < 6; i++)
         do_txn(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].rdy_dly, vecs[i].rv_dly,
                vecs[i].rdata, vecs[i].noise, vecs[i].exp_lat, vecs[i].exp_oh, vecs[i].exp_rdata);

      // reset while waiting for read data discards the transaction
      @(negedge clk_i);
      req_valid_i = 1'b1;
      req_addr_i  = 32'h1000_0020;
      req_we_i    = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk_i);
         s_ready_i  = '0;
         s_rvalid_i = '0;
         case (n)
            1: begin
               req_valid_i = 1'b0;
               chk("rstw_s_valid_req", s_valid_o, 4'b0010);
               s_ready_i = 4'b0010;
            end
            2: begin
               chk("rstw_s_valid_wait", s_valid_o, 4'b0000);
               rst_i = 1'b1;
            end
            3: begin
               chk("rstw_s_valid", s_valid_o, 4'b0000);
               chk("rstw_resp_valid", resp_valid_o, 1'b0);
               chk("rstw_req_ready", req_ready_o, 1'b0);
               chk("rstw_s_addr", s_addr_o, 32'h0);
               rst_i = 1'b0;
               s_rvalid_i = 4'b0010;
               s_rdata_i[32 +: 32] = 32'h7777_7777;
            end
            default: begin
               chk("rstw_resp_valid_late", resp_valid_o, 1'b0);
               chk("rstw_req_ready_after", req_ready_o, 1'b1);
            end
         endcase
      end
      clear_targets();

      // back-to-back requests: read target 0, then write target 3 held pending
      exp_q.push_back(32'h0000_0077);
      exp_q.push_back(32'h0);
      req_valid_i = 1'b1;
      req_addr_i  = 32'h0000_0008;
      req_wdata_i = 32'h0;
      req_we_i    = 1'b0;
      for (int n = 1; n <= 7; n++) begin
         @(negedge clk_i);
         s_ready_i  = '0;
         s_rvalid_i = '0;
         if (n <= 3) chk("b2b_req_ready_busy", req_ready_o, 1'b0);
         case (n)
            1: begin
               chk("b2b_s_valid_rd", s_valid_o, 4'b0001);
               req_addr_i  = 32'h3000_0004;
               req_wdata_i = 32'h0000_55AA;
               req_we_i    = 1'b1;
               s_ready_i   = 4'b0001;
            end
            2: begin
               s_rvalid_i = 4'b0001;
               s_rdata_i[0 +: 32] = 32'h0000_0077;
            end
            3: begin
               chk("b2b_resp1_valid", resp_valid_o, 1'b1);
               exp_d = exp_q.pop_front();
               chk("b2b_resp1_rdata", resp_rdata_o, exp_d);
            end
            4: begin
               chk("b2b_req_ready_free", req_ready_o, 1'b1);
               chk("b2b_resp_gap", resp_valid_o, 1'b0);
            end
            5: begin
               req_valid_i = 1'b0;
               chk("b2b_s_valid_wr", s_valid_o, 4'b1000);
               chk("b2b_s_wdata", s_wdata_o, 32'h0000_55AA);
               chk("b2b_s_we", s_we_o, 1'b1);
               s_ready_i = 4'b1000;
            end
            6: begin
               chk("b2b_resp2_valid", resp_valid_o, 1'b1);
               exp_d = exp_q.pop_front();
               chk("b2b_resp2_rdata", resp_rdata_o, exp_d);
            end
            default: begin
               chk("b2b_resp2_done", resp_valid_o, 1'b0);
               chk("b2b_idle_ready", req_ready_o, 1'b1);
            end
         endcase
      end
      clear_targets();

`ifdef BUS_DEMUX_TIMEOUT_EN
      // silent target: watchdog ends the request with an error response
      @(negedge clk_i);
      req_valid_i = 1'b1;
      req_addr_i  = 32'h1000_0000;
      req_wdata_i = 32'h0000_00AB;
      req_we_i    = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk_i);
         req_valid_i = 1'b0;
         if (n <= 8) chk("to_s_valid", s_valid_o, 4'b0010);
         if (n == 9) begin
            chk("to_s_valid_drop", s_valid_o, 4'b0000);
            chk("to_resp_valid", resp_valid_o, 1'b1);
            chk("to_resp_err", resp_err_o, 1'b1);
            chk("to_resp_rdata", resp_rdata_o, 32'h0);
         end
         if (n == 10) begin
            chk("to_resp_err_clear", resp_err_o, 1'b0);
            chk("to_req_ready", req_ready_o, 1'b1);
         end
      end
      do_txn(32'h1000_0040, 32'h0, 1'b0, 1, 1, 32'h4242_4242, 1'b0, 4, 4'b0010, 32'h4242_4242);
`endif

      // randomized traffic against the reference model
      for (int i = 0; i < 40; i++) begin
         r_addr  = $urandom;
         r_wdata = $urandom;
         r_rdata = $urandom;
         r_we    = 1'($urandom_range(0, 1));
         r_noise = 1'($urandom_range(0, 1));
         r_rdy   = $urandom_range(0, 4);
         r_rv    = $urandom_range(1, 3);
         r_oh    = 4'b0001 << r_addr[29:28];
         do_txn(r_addr, r_wdata, r_we, r_rdy, r_rv, r_rdata, r_noise,
                model_lat(r_we, r_rdy, r_rv), r_oh, r_we ? 32'h0 : r_rdata);
      end

      chk("exp_q_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
